// File: rtl/obstacle_collision_detector.sv
// obstacle_collision_detector
//   Per-pixel collision detector between the obstacle sprite and the step
//   bricks, smiley and shot drawing-request paths. It reports at most one
//   collision and one shot hit per video frame. The collision report carries
//   the obstacle edge that was struck, encoded from the pixel offset inside
//   the sprite.
//
//   Optional feature: when OBSTACLE_HIT_COUNTER_EN is defined, hit_count counts
//   shot hits and saturates at 255. When it is undefined, hit_count is tied to 0.
//
// Ports
//   clk                      system clock
//   resetN                   asynchronous active-low reset
//   startOfFrame             one-clock pulse at the start of each frame
//   obstacle_drawingRequest  current pixel belongs to the obstacle
//   obstacle_offsetX/Y       pixel offset inside the obstacle sprite (unsigned)
//   step_drawingRequest      current pixel belongs to a step brick
//   smiley_drawingRequest    current pixel belongs to the smiley
//   shot_drawingRequest      current pixel belongs to a shot
//   collision                one-clock pulse: obstacle hit a step or the smiley
//   HitEdgeCode              {Left, Top, Right, Bottom} of the last reported hit
//   SHP_shootObstacle        one-clock pulse: a shot overlapped the obstacle
//   hit_count                saturating count of shot hits (optional feature)
module obstacle_collision_detector #(
  parameter int unsigned OBJ_W  = 64,
  parameter int unsigned OBJ_H  = 8,
  parameter int unsigned EDGE_W = 2,
  parameter int unsigned OFFS_W = 11
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              obstacle_drawingRequest,
  input  logic [OFFS_W-1:0] obstacle_offsetX,
  input  logic [OFFS_W-1:0] obstacle_offsetY,
  input  logic              step_drawingRequest,
  input  logic              smiley_drawingRequest,
  input  logic              shot_drawingRequest,
  output logic              collision,
  output logic [3:0]        HitEdgeCode,
  output logic              SHP_shootObstacle,
  output logic [7:0]        hit_count
);

  localparam int unsigned EDGE_CODE_W = 4;
  localparam int unsigned HIT_W       = 8;

  // Edge band thresholds, computed at the width of the offset inputs
  localparam logic [OFFS_W-1:0] LEFT_LIM   = OFFS_W'(EDGE_W);
  localparam logic [OFFS_W-1:0] RIGHT_LIM  = OFFS_W'(OBJ_W - EDGE_W);
  localparam logic [OFFS_W-1:0] TOP_LIM    = OFFS_W'(EDGE_W);
  localparam logic [OFFS_W-1:0] BOTTOM_LIM = OFFS_W'(OBJ_H - EDGE_W);

  typedef enum logic {
    ARMED    = 1'b0,
    REPORTED = 1'b1
  } arm_state_e;

  arm_state_e coll_state, coll_state_nxt;
  arm_state_e shot_state, shot_state_nxt;

  logic                   bump_c;
  logic                   shoot_c;
  logic [EDGE_CODE_W-1:0] edge_code_c;
  logic                   coll_fire_c;
  logic                   shot_fire_c;

  logic                   collision_nxt;
  logic [EDGE_CODE_W-1:0] hit_edge_nxt;
  logic                   shoot_nxt;

  // Overlap terms for the current pixel
  assign bump_c  = obstacle_drawingRequest & (step_drawingRequest | smiley_drawingRequest);
  assign shoot_c = obstacle_drawingRequest & shot_drawingRequest;

  // Edge code {Left, Top, Right, Bottom}. A corner pixel sets two bits.
  assign edge_code_c = {
    (obstacle_offsetX <  LEFT_LIM),
    (obstacle_offsetY <  TOP_LIM),
    (obstacle_offsetX >= RIGHT_LIM),
    (obstacle_offsetY >= BOTTOM_LIM)
  };

  // startOfFrame re-arms first, so an overlap on the frame-start pixel is
  // reported as belonging to the new frame.
  assign coll_fire_c = bump_c  & (startOfFrame | (coll_state == ARMED));
  assign shot_fire_c = shoot_c & (startOfFrame | (shot_state == ARMED));

  // State registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coll_state <= ARMED;
      shot_state <= ARMED;
    end else begin
      coll_state <= coll_state_nxt;
      shot_state <= shot_state_nxt;
    end
  end

  // Next-state logic for both arm/report FSMs
  always_comb begin
    coll_state_nxt = coll_state;
    shot_state_nxt = shot_state;

    if (startOfFrame) begin
      coll_state_nxt = ARMED;
      shot_state_nxt = ARMED;
    end
    if (coll_fire_c) begin
      coll_state_nxt = REPORTED;
    end
    if (shot_fire_c) begin
      shot_state_nxt = REPORTED;
    end
  end

  // Output decode. HitEdgeCode reloads only when a new collision is reported.
  always_comb begin
    collision_nxt = 1'b0;
    hit_edge_nxt  = HitEdgeCode;
    shoot_nxt     = 1'b0;

    if (coll_fire_c) begin
      collision_nxt = 1'b1;
      hit_edge_nxt  = edge_code_c;
    end
    if (shot_fire_c) begin
      shoot_nxt = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      collision         <= 1'b0;
      HitEdgeCode       <= '0;
      SHP_shootObstacle <= 1'b0;
    end else begin
      collision         <= collision_nxt;
      HitEdgeCode       <= hit_edge_nxt;
      SHP_shootObstacle <= shoot_nxt;
    end
  end

`ifdef OBSTACLE_HIT_COUNTER_EN
  // Saturating shot-hit counter. It advances on the same edge as the pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_count <= '0;
    end else if (shot_fire_c && (hit_count != {HIT_W{1'b1}})) begin
      hit_count <= hit_count + HIT_W'(1);
    end
  end
`else
  assign hit_count = HIT_W'(0);
`endif

endmodule
